// File: rtl/extension_inmediato_pipe_if.sv
// Bus bundle for the immediate generator: upstream instruction handshake,
// flush, and the registered downstream result handshake.
// The slave modport is the block's view; the master modport is the view of
// whatever drives it (the fetch side plus the consumer of the result).
interface extension_inmediato_pipe_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
);
    // Upstream side
    logic [31:0]      instruccion_i;
    logic             valido_i;
    logic             listo_o;
    logic             flush_i;

    // Downstream side
    logic [XLEN-1:0]  inmediato_o;
    logic [2:0]       tipo_o;
    logic             ilegal_o;
    logic             valido_o;
    logic             listo_i;

    // Status
    logic [CNT_W-1:0] err_cnt_o;

    modport slave (
        input  instruccion_i,
        input  valido_i,
        input  flush_i,
        input  listo_i,
        output listo_o,
        output inmediato_o,
        output tipo_o,
        output ilegal_o,
        output valido_o,
        output err_cnt_o
    );

    modport master (
        output instruccion_i,
        output valido_i,
        output flush_i,
        output listo_i,
        input  listo_o,
        input  inmediato_o,
        input  tipo_o,
        input  ilegal_o,
        input  valido_o,
        input  err_cnt_o
    );
endinterface

// File: rtl/extension_inmediato_pipe.sv
// Decode-stage immediate generator for RV32I/RV64I.
// Decodes the I, shift-I, S, B, U and J immediate formats, sign-extends the
// result to XLEN, and registers it behind a valid/ready handshake with a
// two-entry skid buffer (output entry + skid entry) so the stage sustains
// one instruction per cycle under backpressure.
//
// Handshake: a transfer happens on a rising clock edge when the producer's
// valid and the consumer's ready are both high. Upstream transfers use
// valido_i/listo_o, downstream transfers use valido_o/listo_i. listo_o is a
// register (the inverse of the skid occupancy), so it never depends
// combinationally on listo_i. Once valido_o is high the output entry holds
// every output stable until it is taken. flush_i overrides all transfers in
// its cycle.
//
// XLEN must be 32 or 64.
module extension_inmediato_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    extension_inmediato_pipe_if.slave bus
);

    // Major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Format codes reported on tipo_o
    localparam logic [2:0] TIPO_R      = 3'd0;
    localparam logic [2:0] TIPO_I      = 3'd1;
    localparam logic [2:0] TIPO_S      = 3'd2;
    localparam logic [2:0] TIPO_B      = 3'd3;
    localparam logic [2:0] TIPO_U      = 3'd4;
    localparam logic [2:0] TIPO_J      = 3'd5;
    localparam logic [2:0] TIPO_SHIFT  = 3'd6;
    localparam logic [2:0] TIPO_ILEGAL = 3'd7;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [31:0]     w_inst;
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_dec_imm;
    logic [2:0]      w_dec_tipo;
    logic            w_dec_ilegal;

    assign w_inst   = bus.instruccion_i;
    assign w_opcode = w_inst[6:0];
    assign w_funct3 = w_inst[14:12];

    // Build a 32-bit immediate per format; every format is already sign- or
    // zero-extended to 32 bits here, so widening to XLEN is a single sign
    // extension (shift amounts have a zero top bit and stay positive).
    always_comb begin
        w_imm32      = '0;
        w_dec_tipo   = TIPO_ILEGAL;
        w_dec_ilegal = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_dec_tipo = TIPO_R;
            end
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                w_dec_tipo = TIPO_I;
                w_imm32    = {{20{w_inst[31]}}, w_inst[31:20]};
            end
            OP_IMM: begin
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    // Shift amount only; inst[30] selects SRAI and is
                    // deliberately excluded.
                    w_dec_tipo = TIPO_SHIFT;
                    if (XLEN == 64) begin
                        w_imm32 = {26'b0, w_inst[25:20]};
                    end else begin
                        w_imm32 = {27'b0, w_inst[24:20]};
                    end
                end else begin
                    w_dec_tipo = TIPO_I;
                    w_imm32    = {{20{w_inst[31]}}, w_inst[31:20]};
                end
            end
            OP_STORE: begin
                w_dec_tipo = TIPO_S;
                w_imm32    = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            end
            OP_BRANCH: begin
                w_dec_tipo = TIPO_B;
                w_imm32    = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25],
                              w_inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                w_dec_tipo = TIPO_U;
                w_imm32    = {w_inst[31:12], 12'b0};
            end
            OP_JAL: begin
                w_dec_tipo = TIPO_J;
                w_imm32    = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                              w_inst[20], w_inst[30:21], 1'b0};
            end
            default: begin
                w_dec_tipo   = TIPO_ILEGAL;
                w_dec_ilegal = 1'b1;
            end
        endcase
    end

    assign w_dec_imm = XLEN'($signed(w_imm32));

    // ------------------------------------------------------------------
    // Output entry, skid entry and upstream ready
    // ------------------------------------------------------------------
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_imm;
    logic [2:0]      r_out_tipo;
    logic            r_out_ilegal;

    logic            r_skid_valid;
    logic [XLEN-1:0] r_skid_imm;
    logic [2:0]      r_skid_tipo;
    logic            r_skid_ilegal;

    logic            r_listo;
    logic [CNT_W-1:0] r_err_cnt;

    logic            w_in_xfer;
    logic            w_out_xfer;

    logic            w_out_valid_d;
    logic [XLEN-1:0] w_out_imm_d;
    logic [2:0]      w_out_tipo_d;
    logic            w_out_ilegal_d;
    logic            w_skid_valid_d;
    logic [XLEN-1:0] w_skid_imm_d;
    logic [2:0]      w_skid_tipo_d;
    logic            w_skid_ilegal_d;

    // A flushed cycle accepts nothing, so it never counts as an input transfer.
    assign w_in_xfer  = bus.valido_i && r_listo && !bus.flush_i;
    assign w_out_xfer = r_out_valid && bus.listo_i;

    // Next state of both entries: flush empties them; a free or departing
    // output entry refills from the skid entry first (FIFO order), otherwise
    // from the input; a held output entry diverts a new input to the skid.
    always_comb begin
        w_out_valid_d   = r_out_valid;
        w_out_imm_d     = r_out_imm;
        w_out_tipo_d    = r_out_tipo;
        w_out_ilegal_d  = r_out_ilegal;
        w_skid_valid_d  = r_skid_valid;
        w_skid_imm_d    = r_skid_imm;
        w_skid_tipo_d   = r_skid_tipo;
        w_skid_ilegal_d = r_skid_ilegal;

        if (bus.flush_i) begin
            w_out_valid_d  = 1'b0;
            w_skid_valid_d = 1'b0;
        end else if (!r_out_valid || w_out_xfer) begin
            if (r_skid_valid) begin
                // listo_o is low while the skid is full, so no input competes.
                w_out_valid_d  = 1'b1;
                w_out_imm_d    = r_skid_imm;
                w_out_tipo_d   = r_skid_tipo;
                w_out_ilegal_d = r_skid_ilegal;
                w_skid_valid_d = 1'b0;
            end else if (w_in_xfer) begin
                w_out_valid_d  = 1'b1;
                w_out_imm_d    = w_dec_imm;
                w_out_tipo_d   = w_dec_tipo;
                w_out_ilegal_d = w_dec_ilegal;
            end else begin
                w_out_valid_d  = 1'b0;
            end
        end else if (w_in_xfer) begin
            w_skid_valid_d  = 1'b1;
            w_skid_imm_d    = w_dec_imm;
            w_skid_tipo_d   = w_dec_tipo;
            w_skid_ilegal_d = w_dec_ilegal;
        end
    end

    // Register both entries and the upstream ready (inverse of skid occupancy).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid   <= 1'b0;
            r_out_imm     <= '0;
            r_out_tipo    <= TIPO_R;
            r_out_ilegal  <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_skid_imm    <= '0;
            r_skid_tipo   <= TIPO_R;
            r_skid_ilegal <= 1'b0;
            r_listo       <= 1'b1;
        end else begin
            r_out_valid   <= w_out_valid_d;
            r_out_imm     <= w_out_imm_d;
            r_out_tipo    <= w_out_tipo_d;
            r_out_ilegal  <= w_out_ilegal_d;
            r_skid_valid  <= w_skid_valid_d;
            r_skid_imm    <= w_skid_imm_d;
            r_skid_tipo   <= w_skid_tipo_d;
            r_skid_ilegal <= w_skid_ilegal_d;
            r_listo       <= !w_skid_valid_d;
        end
    end

    // Saturating count of illegal instructions actually accepted upstream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_cnt <= '0;
        end else if (w_in_xfer && w_dec_ilegal && (r_err_cnt != CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign bus.listo_o     = r_listo;
    assign bus.valido_o    = r_out_valid;
    assign bus.inmediato_o = r_out_imm;
    assign bus.tipo_o      = r_out_tipo;
    assign bus.ilegal_o    = r_out_ilegal;
    assign bus.err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_extension_inmediato_pipe.sv
// Directed bench for extension_inmediato_pipe. Two instances share one
// stimulus stream: dut_a (XLEN=32, CNT_W=2) and dut_b (XLEN=64, CNT_W=8).
module tb_extension_inmediato_pipe;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Shared stimulus
    logic [31:0] instr;
    logic        valid_in;
    logic        flush;
    logic        ready_out;

    int checks = 0;
    int errors = 0;

    extension_inmediato_pipe_if #(.XLEN(32), .CNT_W(2)) bus_a ();
    extension_inmediato_pipe_if #(.XLEN(64), .CNT_W(8)) bus_b ();

    assign bus_a.instruccion_i = instr;
    assign bus_a.valido_i      = valid_in;
    assign bus_a.flush_i       = flush;
    assign bus_a.listo_i       = ready_out;
    assign bus_b.instruccion_i = instr;
    assign bus_b.valido_i      = valid_in;
    assign bus_b.flush_i       = flush;
    assign bus_b.listo_i       = ready_out;

    extension_inmediato_pipe #(.XLEN(32), .CNT_W(2)) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_a)
    );

    extension_inmediato_pipe #(.XLEN(64), .CNT_W(8)) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_b)
    );

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs changed 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic v, input logic [31:0] imm,
                           input logic [2:0] tipo, input logic il);
        check({tag, ".a.valid"},  {63'b0, bus_a.valido_o}, {63'b0, v});
        check({tag, ".a.imm"},    {32'b0, bus_a.inmediato_o}, {32'b0, imm});
        check({tag, ".a.tipo"},   {61'b0, bus_a.tipo_o}, {61'b0, tipo});
        check({tag, ".a.ilegal"}, {63'b0, bus_a.ilegal_o}, {63'b0, il});
    endtask

    task automatic check_b_imm(input string tag, input logic [63:0] imm, input logic [2:0] tipo);
        check({tag, ".b.imm"},  bus_b.inmediato_o, imm);
        check({tag, ".b.tipo"}, {61'b0, bus_b.tipo_o}, {61'b0, tipo});
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n     = 1'b0;
        instr     = 32'h0;
        valid_in  = 1'b0;
        flush     = 1'b0;
        ready_out = 1'b1;
        step();
        step();

        // Reset state
        check_a("reset", 1'b0, 32'h0, 3'd0, 1'b0);
        check("reset.a.listo", {63'b0, bus_a.listo_o}, 64'd1);
        check("reset.a.cnt",   {62'b0, bus_a.err_cnt_o}, 64'd0);
        check("reset.b.valid", {63'b0, bus_b.valido_o}, 64'd0);
        check("reset.b.imm",   bus_b.inmediato_o, 64'd0);

        rst_n = 1'b1;
        step();
        check("idle.a.valid", {63'b0, bus_a.valido_o}, 64'd0);

        // Streaming decode, one instruction per cycle, no backpressure
        valid_in = 1'b1;
        instr = 32'hFFF00093;                  // addi x1,x0,-1
        step();
        check_a("addi", 1'b1, 32'hFFFFFFFF, 3'd1, 1'b0);
        check_b_imm("addi", 64'hFFFFFFFF_FFFFFFFF, 3'd1);

        instr = 32'hFE112E23;                  // sw x1,-4(x2)
        step();
        check_a("sw", 1'b1, 32'hFFFFFFFC, 3'd2, 1'b0);
        check_b_imm("sw", 64'hFFFFFFFF_FFFFFFFC, 3'd2);

        instr = 32'h4030D093;                  // srai x1,x1,3
        step();
        check_a("srai", 1'b1, 32'h00000003, 3'd6, 1'b0);
        check_b_imm("srai", 64'h3, 3'd6);

        instr = 32'h03F09093;                  // slli x1,x1,63 (shamt bit 5 set)
        step();
        check_a("slli63", 1'b1, 32'h0000001F, 3'd6, 1'b0);
        check_b_imm("slli63", 64'h3F, 3'd6);

        instr = 32'h123452B7;                  // lui x5,0x12345
        step();
        check_a("lui", 1'b1, 32'h12345000, 3'd4, 1'b0);
        check_b_imm("lui", 64'h12345000, 3'd4);

        instr = 32'h0010006F;                  // jal x0,+2048
        step();
        check_a("jal", 1'b1, 32'h00000800, 3'd5, 1'b0);
        check_b_imm("jal", 64'h800, 3'd5);

        instr = 32'h800002B7;                  // lui x5,0x80000
        step();
        check_a("lui_neg", 1'b1, 32'h80000000, 3'd4, 1'b0);
        check_b_imm("lui_neg", 64'hFFFFFFFF_80000000, 3'd4);

        instr = 32'hFE000EE3;                  // beq x0,x0,-4
        step();
        check_a("beq", 1'b1, 32'hFFFFFFFC, 3'd3, 1'b0);
        check_b_imm("beq", 64'hFFFFFFFF_FFFFFFFC, 3'd3);

        instr = 32'h003100B3;                  // add x1,x2,x3
        step();
        check_a("add", 1'b1, 32'h0, 3'd0, 1'b0);

        valid_in = 1'b0;
        step();
        check("drain.a.valid", {63'b0, bus_a.valido_o}, 64'd0);

        // Backpressure: three back-to-back inputs with the consumer stalled
        ready_out = 1'b0;
        valid_in  = 1'b1;
        instr     = 32'h00500093;              // addi x1,x0,5
        step();
        check_a("bp_first", 1'b1, 32'd5, 3'd1, 1'b0);
        check("bp_first.a.listo", {63'b0, bus_a.listo_o}, 64'd1);

        instr = 32'h00A00093;                  // addi x1,x0,10 -> skid
        step();
        check_a("bp_second", 1'b1, 32'd5, 3'd1, 1'b0);
        check("bp_second.a.listo", {63'b0, bus_a.listo_o}, 64'd0);

        instr = 32'h00F00093;                  // addi x1,x0,15 -> held upstream
        step();
        check_a("bp_hold1", 1'b1, 32'd5, 3'd1, 1'b0);
        check("bp_hold1.a.listo", {63'b0, bus_a.listo_o}, 64'd0);
        step();
        check_a("bp_hold2", 1'b1, 32'd5, 3'd1, 1'b0);
        check("bp_hold2.a.listo", {63'b0, bus_a.listo_o}, 64'd0);

        ready_out = 1'b1;
        step();
        check_a("bp_out2", 1'b1, 32'd10, 3'd1, 1'b0);
        check("bp_out2.a.listo", {63'b0, bus_a.listo_o}, 64'd1);
        step();
        check_a("bp_out3", 1'b1, 32'd15, 3'd1, 1'b0);
        valid_in = 1'b0;
        step();
        check("bp_empty.a.valid", {63'b0, bus_a.valido_o}, 64'd0);

        // Illegal opcodes and counter saturation (CNT_W=2 on dut_a)
        valid_in = 1'b1;
        instr    = 32'h0000007F;
        step();
        check_a("ileg1", 1'b1, 32'h0, 3'd7, 1'b1);
        check("ileg1.a.cnt", {62'b0, bus_a.err_cnt_o}, 64'd1);
        step();
        check_a("ileg2", 1'b1, 32'h0, 3'd7, 1'b1);
        check("ileg2.a.cnt", {62'b0, bus_a.err_cnt_o}, 64'd2);
        step();
        check("ileg3.a.cnt", {62'b0, bus_a.err_cnt_o}, 64'd3);
        step();
        check_a("ileg4", 1'b1, 32'h0, 3'd7, 1'b1);
        check("ileg4.a.cnt", {62'b0, bus_a.err_cnt_o}, 64'd3);
        step();
        check_a("ileg5", 1'b1, 32'h0, 3'd7, 1'b1);
        check("ileg5.a.cnt", {62'b0, bus_a.err_cnt_o}, 64'd3);
        check("ileg5.b.cnt", {56'b0, bus_b.err_cnt_o}, 64'd5);
        valid_in = 1'b0;
        step();

        // Flush with both entries full
        ready_out = 1'b0;
        valid_in  = 1'b1;
        instr     = 32'h00100093;              // addi x1,x0,1
        step();
        instr     = 32'h00200093;              // addi x1,x0,2 -> skid
        step();
        check("fl_full.a.listo", {63'b0, bus_a.listo_o}, 64'd0);
        valid_in = 1'b0;
        flush    = 1'b1;
        step();
        check("fl.a.valid", {63'b0, bus_a.valido_o}, 64'd0);
        check("fl.a.listo", {63'b0, bus_a.listo_o}, 64'd1);
        check("fl.b.cnt",   {56'b0, bus_b.err_cnt_o}, 64'd5);

        // Flush with a same-cycle input: dropped and not counted
        ready_out = 1'b1;
        valid_in  = 1'b1;
        instr     = 32'h0000007F;
        step();
        check("fl_in.a.valid", {63'b0, bus_a.valido_o}, 64'd0);
        check("fl_in.b.cnt",   {56'b0, bus_b.err_cnt_o}, 64'd5);
        flush    = 1'b0;
        valid_in = 1'b0;
        step();
        check("fl_after.a.valid", {63'b0, bus_a.valido_o}, 64'd0);
        check("fl_after.b.valid", {63'b0, bus_b.valido_o}, 64'd0);

        // Asynchronous reset between clock edges
        ready_out = 1'b0;
        valid_in  = 1'b1;
        instr     = 32'hFFF00093;
        step();
        instr     = 32'h0000007F;
        step();
        valid_in  = 1'b0;
        check("pre_rst.a.listo", {63'b0, bus_a.listo_o}, 64'd0);
        check("pre_rst.b.cnt",   {56'b0, bus_b.err_cnt_o}, 64'd6);
        check_a("pre_rst", 1'b1, 32'hFFFFFFFF, 3'd1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_a("async_rst", 1'b0, 32'h0, 3'd0, 1'b0);
        check("async_rst.a.listo", {63'b0, bus_a.listo_o}, 64'd1);
        check("async_rst.a.cnt",   {62'b0, bus_a.err_cnt_o}, 64'd0);
        check("async_rst.b.cnt",   {56'b0, bus_b.err_cnt_o}, 64'd0);
        check("async_rst.b.imm",   bus_b.inmediato_o, 64'd0);
        step();
        rst_n     = 1'b1;
        ready_out = 1'b1;
        step();
        check("post_rst.a.valid", {63'b0, bus_a.valido_o}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/extension_inmediato_pipe.md
Name: extension_inmediato_pipe

Overview:
- Parametrised immediate generator for the pipelined core's decode stage; successor to the combinational I-type-only sign extender.
- Decodes all RV32I/RV64I immediate formats (I, shift-I, S, B, U, J) and sign- or zero-extends the result to XLEN.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, supporting full throughput under backpressure.
- Adds flush, an illegal-opcode flag and a saturating illegal-opcode counter.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- instruccion_i  in  32  instruction word from fetch.
- valido_i  in  1  instruccion_i is valid.
- listo_o  out  1  block can accept an input this cycle.
- flush_i  in  1  synchronous pipeline flush.
- inmediato_o  out  XLEN  extended immediate.
- tipo_o  out  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 shift-I, 7 illegal.
- ilegal_o  out  1  opcode not recognised.
- valido_o  out  1  output entry valid.
- listo_i  in  1  downstream accepts the output.
- err_cnt_o  out  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (async, rst_ni=0): valido_o=0, inmediato_o=0, tipo_o=0, ilegal_o=0, err_cnt_o=0, skid buffer empty, listo_o=1.
- Opcode decode of instruccion_i[6:0]:
  - 0110011 → R, immediate 0.
  - 0000011, 1100111, 1110011 → I.
  - 0010011 → I, except funct3 001/101 → shift-I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Any other opcode → illegal: immediate 0, ilegal_o=1.
- Immediate construction (sext = sign-extend from the top bit to XLEN):
  - I: sext(inst[31:20]).
  - shift-I: zero-extend inst[24:20] when XLEN=32, inst[25:20] when XLEN=64; inst[30] (SRAI marker) is never part of the immediate.
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U: sext({inst[31:12], 12'b0}).
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- Handshake:
  - Input transfer when valido_i && listo_o.
  - Output transfer when valido_o && listo_i.
  - Latency: 1 cycle from input transfer to valido_o when the output stage is empty.
  - The output entry holds all outputs stable while valido_o && !listo_i.
- Skid buffer:
  - An input accepted while the output entry is held goes to the skid entry.
  - listo_o is registered and equals !skid_valid.
  - On an output transfer, the skid entry moves to the output entry and listo_o rises the next cycle.
  - Order is strictly FIFO.
  - Simultaneous input and output transfer with the skid empty: the output entry is replaced, no bubble.
- flush_i (synchronous) has priority over every transfer that cycle:
  - Both entries are invalidated: valido_o=0 and listo_o=1 next cycle.
  - A same-cycle input is discarded and not counted.
  - err_cnt_o is preserved.
- err_cnt_o increments by 1 on each accepted illegal input and saturates at 2^CNT_W-1.
- Reset asserted mid-operation clears everything immediately, regardless of clock.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), listo_i=1 → next cycle valido_o=1, inmediato_o=0xFFFFFFFF, tipo_o=1.
- sw x1,-4(x2) (0xFE112E23) → 0xFFFFFFFC, tipo 2; srai x1,x1,3 (0x4030D093) → 0x00000003, tipo 6.
- lui x5,0x12345 (0x123452B7) → 0x12345000, tipo 4; jal x0,+2048 (0x0010006F) → 0x00000800, tipo 5; with XLEN=64, lui 0x80000 (0x800002B7) → 0xFFFFFFFF80000000.
- Backpressure: listo_i=0, three back-to-back valid inputs → first two accepted, listo_o=0 from the cycle after the second, third held upstream; then listo_i=1 → outputs appear in order with no loss or duplication.
- Illegal: CNT_W=2, five 0x0000007F inputs → each output has ilegal_o=1, tipo 7, imm 0; err_cnt_o goes 1, 2, 3, 3, 3.
- Flush with both entries full → valido_o=0, listo_o=1 next cycle; a same-cycle input is dropped.
- rst_ni pulsed low between clock edges → all outputs reset without waiting for a clock edge.
